// File: rtl/tt_um_hoene_manchester_encoder_pkg.sv
// Shared definitions for the Manchester encoder: FSM states, clamp default and
// the line polarity convention also used by the decoder.
package tt_um_hoene_manchester_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } enc_state_t;

    localparam int MIN_HALF_DEFAULT = 2;

    // A logical 1 is a low-to-high transition in the middle of the bit cell.
    localparam logic ONE_IS_RISING = 1'b1;

    function automatic logic first_half_level(input logic b);
        return b ^ ONE_IS_RISING;
    endfunction

    function automatic logic second_half_level(input logic b);
        return ~(b ^ ONE_IS_RISING);
    endfunction

endpackage

// File: rtl/tt_um_hoene_manchester_encoder_bit_fifo.sv
// One-bit-wide synchronous FIFO with show-ahead read data and a flush input.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module tt_um_hoene_bit_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  logic wr_data,
    output logic rd_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_en   = pop && !empty && !flush;
    assign wr_en   = push && (!full || rd_en) && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/tt_um_hoene_manchester_encoder.sv
// Re-encodes the decoded bit stream as Manchester code on a single registered
// output pin, buffering bits in a small FIFO and regenerating the half-bit timing.
module tt_um_hoene_manchester_encoder
    import tt_um_hoene_manchester_encoder_pkg::*;
#(
    parameter int   FIFO_DEPTH = 4,
    parameter int   PW_WIDTH   = 6,
    parameter int   MIN_HALF   = MIN_HALF_DEFAULT,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_data,
    input  logic                in_clk,
    input  logic                in_swap,
    input  logic                in_sync,
    input  logic [PW_WIDTH-1:0] in_pulsewidth,
    output logic                out,
    output logic                busy,
    output logic                overflow
);
    localparam logic [PW_WIDTH-1:0] MIN_H = PW_WIDTH'(MIN_HALF);

    enc_state_t          state_q, state_d;
    logic [PW_WIDTH-1:0] count_q, count_d;
    logic [PW_WIDTH-1:0] half_q, half_d;
    logic                bit_q, bit_d;
    logic                out_q, out_d;
    logic                sync_q;
    logic                overflow_q;

    logic                push;
    logic                flush;
    logic                pop;
    logic                can_pop;
    logic                fifo_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [PW_WIDTH-1:0] half_in;

    assign push    = in_clk && in_sync;
    assign flush   = sync_q && !in_sync;
    assign can_pop = !fifo_empty && !flush;
    assign half_in = (in_pulsewidth < MIN_H) ? MIN_H : in_pulsewidth;

    tt_um_hoene_bit_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_data ^ in_swap),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The output register is loaded with the level of the next cycle, so the
    // first half appears on the line the cycle after the pop.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        half_d  = half_q;
        bit_d   = bit_q;
        out_d   = out_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                out_d = IDLE_LEVEL;
                if (can_pop) begin
                    pop     = 1'b1;
                    bit_d   = fifo_data;
                    half_d  = half_in;
                    count_d = half_in - PW_WIDTH'(1);
                    out_d   = first_half_level(fifo_data);
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (count_q == '0) begin
                    count_d = half_q - PW_WIDTH'(1);
                    out_d   = second_half_level(bit_q);
                    state_d = ST_SECOND;
                end else begin
                    count_d = count_q - PW_WIDTH'(1);
                end
            end
            ST_SECOND: begin
                if (count_q != '0) begin
                    count_d = count_q - PW_WIDTH'(1);
                end else if (can_pop) begin
                    pop     = 1'b1;
                    bit_d   = fifo_data;
                    half_d  = half_in;
                    count_d = half_in - PW_WIDTH'(1);
                    out_d   = first_half_level(fifo_data);
                    state_d = ST_FIRST;
                end else begin
                    out_d   = IDLE_LEVEL;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                out_d   = IDLE_LEVEL;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            half_q  <= MIN_H;
            bit_q   <= 1'b0;
            out_q   <= IDLE_LEVEL;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            out_q   <= out_d;
            sync_q  <= in_sync;
        end
    end

    // A fresh lock clears the sticky flag in preference to a same-cycle drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (!sync_q && in_sync) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign out      = out_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Self-checking bench for the Manchester encoder: directed scenarios plus a
// randomized run checked against a time-based transmission model.
module tb_tt_um_hoene_manchester_encoder;

    localparam logic IDLE = 1'b0;
    localparam int   DEPTH = 4;
    localparam int   MINH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_data = 1'b0;
    logic       in_clk = 1'b0;
    logic       in_swap = 1'b0;
    logic       in_sync = 1'b0;
    logic [5:0] in_pulsewidth = 6'd0;
    logic       out;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int q[$];
    int tx_start = 0;
    int tx_h = 0;
    int tx_end = 0;
    int tx_bit = 0;
    bit prev_sync = 1'b0;
    bit m_ovf = 1'b0;

    tt_um_hoene_manchester_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_clk        (in_clk),
        .in_swap       (in_swap),
        .in_sync       (in_sync),
        .in_pulsewidth (in_pulsewidth),
        .out           (out),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic exp_out();
        if (cyc >= tx_start && cyc < tx_start + tx_h) return logic'(tx_bit == 0);
        if (cyc >= tx_start + tx_h && cyc < tx_end) return logic'(tx_bit != 0);
        return IDLE;
    endfunction

    function automatic logic exp_busy();
        return logic'((cyc < tx_end) || (q.size() > 0));
    endfunction

    task automatic model_reset();
        q.delete();
        tx_start = 0;
        tx_h = 0;
        tx_end = 0;
        tx_bit = 0;
        prev_sync = 1'b0;
        m_ovf = 1'b0;
    endtask

    // A bit occupies the line from the cycle after its pop for 2*H cycles; the
    // next pop may happen in the last line cycle of the current bit.
    task automatic model_step(input bit d, input bit s, input bit sw, input bit sy, input int pw);
        bit flush;
        flush = prev_sync && !sy;
        if (!flush && q.size() > 0 && cyc >= tx_end - 1) begin
            tx_bit = q.pop_front();
            tx_start = cyc + 1;
            tx_h = (pw < MINH) ? MINH : pw;
            tx_end = tx_start + 2 * tx_h;
        end
        if (flush) q.delete();
        if (s && sy) begin
            if (q.size() < DEPTH) q.push_back(int'(d ^ sw));
            else m_ovf = 1'b1;
        end
        if (!prev_sync && sy) m_ovf = 1'b0;
        prev_sync = sy;
    endtask

    task automatic tick(input logic d, input logic s, input logic sw, input logic sy, input logic [5:0] pw);
        in_data = d;
        in_clk = s;
        in_swap = sw;
        in_sync = sy;
        in_pulsewidth = pw;
        @(posedge clk);
        model_step(d, s, sw, sy, int'(pw));
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (out !== IDLE) begin failures++; $display("[TB] FAIL reset_out got=%b exp=%b", out, IDLE); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", overflow); end
        rst_n = 1'b1;
        model_reset();
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
    endtask

    task automatic test_single_bit(input logic sw);
        logic b, eo, eb;
        b = 1'b1 ^ sw;
        tick(1'b1, 1'b1, sw, 1'b1, 6'd4);
        for (int rel = 1; rel <= 14; rel++) begin
            eo = (rel >= 2 && rel <= 5) ? ~b : (rel >= 6 && rel <= 9) ? b : IDLE;
            eb = logic'(rel >= 1 && rel <= 9);
            checks += 2;
            if (out !== eo) begin failures++; $display("[TB] FAIL single_out swap=%b rel=%0d got=%b exp=%b", sw, rel, out, eo); end
            if (busy !== eb) begin failures++; $display("[TB] FAIL single_busy swap=%b rel=%0d got=%b exp=%b", sw, rel, busy, eb); end
            tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
        end
    endtask

    task automatic test_stream();
        logic [7:0] pattern, decoded;
        logic first_h;
        pattern = 8'b10110010;
        decoded = 8'd0;
        first_h = 1'b0;
        for (int rel = 0; rel < 74; rel++) begin
            checks += 3;
            if (out !== exp_out()) begin failures++; $display("[TB] FAIL stream_out rel=%0d got=%b exp=%b", rel, out, exp_out()); end
            if (busy !== exp_busy()) begin failures++; $display("[TB] FAIL stream_busy rel=%0d got=%b exp=%b", rel, busy, exp_busy()); end
            if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL stream_ovf rel=%0d got=%b exp=0", rel, overflow); end
            if (rel >= 2 && rel < 66) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("[TB] FAIL stream_gap rel=%0d got=%b exp=1", rel, busy); end
                if ((rel - 2) % 8 == 1) first_h = out;
                if ((rel - 2) % 8 == 6) begin
                    decoded[7 - (rel - 2) / 8] = out;
                    checks++;
                    if (first_h !== ~out) begin failures++; $display("[TB] FAIL stream_code rel=%0d got=%b exp=%b", rel, first_h, ~out); end
                end
            end
            if (rel % 8 == 0 && rel / 8 < 8) tick(pattern[7 - rel / 8], 1'b1, 1'b0, 1'b1, 6'd4);
            else tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
        end
        checks++;
        if (decoded !== pattern) begin failures++; $display("[TB] FAIL stream_decode got=%b exp=%b", decoded, pattern); end
    endtask

    task automatic test_overflow();
        int busy_cycles;
        busy_cycles = 0;
        for (int rel = 0; rel < 230; rel++) begin
            checks += 3;
            if (out !== exp_out()) begin failures++; $display("[TB] FAIL ovf_out rel=%0d got=%b exp=%b", rel, out, exp_out()); end
            if (busy !== exp_busy()) begin failures++; $display("[TB] FAIL ovf_busy rel=%0d got=%b exp=%b", rel, busy, exp_busy()); end
            if (overflow !== m_ovf) begin failures++; $display("[TB] FAIL ovf_flag rel=%0d got=%b exp=%b", rel, overflow, m_ovf); end
            if (rel == 6) begin
                checks++;
                if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_rise got=%b exp=1", overflow); end
            end
            if (busy === 1'b1) busy_cycles++;
            if (rel < 6) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 6'd20);
            else tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd20);
        end
        checks++;
        if (busy_cycles != 201) begin failures++; $display("[TB] FAIL ovf_five_bits got=%0d exp=201", busy_cycles); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 6'd20);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow); end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd20);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_clamp_flush();
        logic d0, eo;
        d0 = 1'($urandom_range(0, 1));
        for (int rel = 0; rel < 14; rel++) begin
            checks += 2;
            if (out !== exp_out()) begin failures++; $display("[TB] FAIL flush_out rel=%0d got=%b exp=%b", rel, out, exp_out()); end
            if (busy !== exp_busy()) begin failures++; $display("[TB] FAIL flush_busy rel=%0d got=%b exp=%b", rel, busy, exp_busy()); end
            if (rel >= 2) begin
                eo = (rel <= 3) ? ~d0 : (rel <= 5) ? d0 : IDLE;
                checks++;
                if (out !== eo) begin failures++; $display("[TB] FAIL flush_line rel=%0d got=%b exp=%b", rel, out, eo); end
            end
            if (rel >= 6) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle rel=%0d got=%b exp=0", rel, busy); end
            end
            if (rel == 0) tick(d0, 1'b1, 1'b0, 1'b1, 6'd0);
            else if (rel < 4) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 6'd0);
            else tick(1'b0, 1'b0, 1'b0, logic'(rel >= 9), 6'd0);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b1, 6'd4);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
        checks++;
        if (out !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre got=%b exp=1", out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (out !== IDLE) begin failures++; $display("[TB] FAIL areset_out got=%b exp=%b", out, IDLE); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL areset_busy got=%b exp=0", busy); end
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            checks += 2;
            if (out !== IDLE) begin failures++; $display("[TB] FAIL areset_resid i=%0d got=%b exp=%b", i, out, IDLE); end
            if (busy !== 1'b0) begin failures++; $display("[TB] FAIL areset_idle i=%0d got=%b exp=0", i, busy); end
            tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
        end
    endtask

    task automatic test_random();
        int low_cnt, pw_r;
        logic sy;
        low_cnt = 0;
        pw_r = 3;
        for (int i = 0; i < 400; i++) begin
            checks += 3;
            if (out !== exp_out()) begin failures++; $display("[TB] FAIL rand_out i=%0d got=%b exp=%b", i, out, exp_out()); end
            if (busy !== exp_busy()) begin failures++; $display("[TB] FAIL rand_busy i=%0d got=%b exp=%b", i, busy, exp_busy()); end
            if (overflow !== m_ovf) begin failures++; $display("[TB] FAIL rand_ovf i=%0d got=%b exp=%b", i, overflow, m_ovf); end
            if (low_cnt == 0 && $urandom_range(0, 39) == 0) low_cnt = int'($urandom_range(1, 3));
            sy = logic'(low_cnt == 0);
            if (low_cnt > 0) low_cnt--;
            if ($urandom_range(0, 15) == 0) pw_r = int'($urandom_range(0, 5));
            tick(1'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), sy, 6'(pw_r));
        end
    endtask

    initial begin
        test_reset();
        test_single_bit(1'b0);
        test_single_bit(1'b1);
        test_stream();
        test_overflow();
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
        test_clamp_flush();
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1, 6'd4);
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_hoene_manchester_encoder.md
# tt_um_hoene_manchester_encoder

Re-encodes the decoded, optionally bit-swapped protocol stream as Manchester code on one output pin, so the LED chain can be daisy-chained to the next device. It sits downstream of the Manchester decoder and protocol-select stages. It consumes the recovered bit strobes, the swap request and the measured half-bit width, buffers bits in a small FIFO, and regenerates line timing.

## Interface
- FIFO_DEPTH, 4, bit buffer depth (power of two, ≥2)
- PW_WIDTH, 6, width of half-bit period input
- MIN_HALF, 2, minimum half-bit length in clk cycles (clamp)
- IDLE_LEVEL, 0, line level when not transmitting
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  1  decoded bit, valid when in_clk=1
- in_clk  in  1  one-cycle strobe per decoded bit (clk domain)
- in_swap  in  1  invert this bit before forwarding, sampled with in_clk
- in_sync  in  1  upstream frame lock; 0 = no valid stream
- in_pulsewidth  in  PW_WIDTH  measured half-bit length in clk cycles
- out  out  1  Manchester line output, registered
- busy  out  1  bit in flight or FIFO non-empty
- overflow  out  1  sticky: a strobe was dropped because the FIFO was full

## Operation
- Push: on in_clk=1 and in_sync=1, write (in_data ^ in_swap) into FIFO. Strobes with in_sync=0 are ignored.
- Encoding: bit b is sent as first half = !b, second half = b. A 1 is low→high; a 0 is high→low.
- FSM states:
  - IDLE: out=IDLE_LEVEL. If FIFO non-empty, pop → FIRST.
  - FIRST: hold !b for H cycles → SECOND.
  - SECOND: hold b for H cycles. At the last cycle, pop → FIRST if FIFO non-empty, else → IDLE.
- H = max(in_pulsewidth, MIN_HALF), latched at each pop. H stays constant within a bit.
- Half counter counts H-1 down to 0. It is PW_WIDTH wide, so no wrap.
- FIFO full with push and pop in the same cycle: both occur, and the bit is accepted.
- FIFO full with push and no pop: drop the bit and set overflow.
- in_sync falling: flush the FIFO in that cycle. The bit in flight completes both halves, then the FSM goes to IDLE. Pushes in the same cycle are discarded.
- overflow clears only on reset or on an in_sync rising edge.
- Reset mid-bit: immediate return to IDLE, FIFO empty, out=IDLE_LEVEL.

## Timing
- Reset values: out=IDLE_LEVEL, busy=0, overflow=0, FSM=IDLE, FIFO empty, H=MIN_HALF.
- Latency: strobe in cycle t with FIFO empty and FSM IDLE:
  - FIFO non-empty in t+1; pop at end of t+1.
  - First half on out from t+2.
  - Strobe-to-line latency is 2 cycles.
- Bit duration is exactly 2·H cycles. Back-to-back bits have zero gap cycles.
- busy goes 1 in t+1 and goes 0 in the first IDLE cycle after the last second half.
- overflow rises in the cycle after the dropped strobe.

## Structure
- Shared package holds the FSM state encoding (IDLE/FIRST/SECOND) and the MIN_HALF default. It also holds the Manchester polarity convention, shared with the decoder.
- One sub-module, tt_um_hoene_bit_fifo: a 1-bit-wide synchronous FIFO with push, pop, full, empty and flush, on the same clk/rst_n.
- Counter, FSM and output register are in the top of this block.

## Test plan
- Single bit: in_pulsewidth=4, strobe in_data=1 at cycle 10.
  - out=0 for cycles 12–15, out=1 for cycles 16–19, IDLE_LEVEL from 20.
  - busy high for cycles 11–19.
- Swap: the same strobe with in_swap=1 sends a 0, so out=1 for cycles 12–15 and 0 for cycles 16–19.
- Stream: 8 bits 10110010 strobed every 8 cycles, in_pulsewidth=4.
  - Continuous 64-cycle waveform with no gaps; decoding it reproduces 10110010.
  - overflow stays 0.
- Overflow: in_pulsewidth=20, 6 strobes on consecutive cycles.
  - One bit is popped, 4 are queued, the 6th is dropped and overflow=1.
  - 5 bits are transmitted.
  - An in_sync 0→1 clears overflow.
- Clamp and flush:
  - in_pulsewidth=0 gives halves of 2 cycles.
  - Dropping in_sync mid-bit with 3 bits queued completes the current bit only, then out returns to IDLE_LEVEL.
- Async reset: assert rst_n=0 mid-first-half. out goes to IDLE_LEVEL and busy to 0 without waiting for a clk edge, and no residual bits appear after release.
